// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encoding and instruction constants for the hazard controller.
package hazard_ctrl_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2, HALT = 2'd3} state_t;
    localparam logic [31:0] NOP_INSN  = 32'h00000013;
    localparam logic [31:0] HALT_INSN = 32'hFFFFFFFF;
endpackage

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect: combinational load-use hazard detection between ID sources and the EX load.
module hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_is_load,
    output logic                  lu
);
    assign lu = ex_is_load && ex_reg_write && (ex_rd != '0) &&
                ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline pause/nop/flush/halt sequencer with Mealy outputs.
// Optional HAZARD_PERF_EN adds stall_cycles/flush_cycles performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  id_halt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_is_load,
    input  logic                  ex_branch_taken,
    input  logic                  resume,
    output logic                  pause,
    output logic                  nop,
    output logic                  flush,
    output logic                  halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_cycles
`endif
);
    localparam logic [2:0] LL_M1 = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FC_M1 = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       lu, p, n, f, h;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd       (ex_rd),
        .ex_reg_write(ex_reg_write),
        .ex_is_load  (ex_is_load),
        .lu          (lu)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        p = 1'b0;
        n = 1'b0;
        f = 1'b0;
        h = 1'b0;
        case (state)
            RUN, STALL: begin
                if (ex_branch_taken) begin
                    f         = 1'b1;
                    n         = 1'b1;
                    state_nxt = FLUSH_CYCLES > 1 ? FLUSH : RUN;
                    cnt_nxt   = FLUSH_CYCLES > 1 ? FC_M1 : 3'd0;
                end else if (state == STALL) begin
                    p         = 1'b1;
                    n         = 1'b1;
                    cnt_nxt   = cnt == 3'd0 ? 3'd0 : cnt - 3'd1;
                    state_nxt = cnt <= 3'd1 ? RUN : STALL;
                end else if (lu) begin
                    p         = 1'b1;
                    n         = 1'b1;
                    state_nxt = LOAD_LAT > 1 ? STALL : RUN;
                    cnt_nxt   = LOAD_LAT > 1 ? LL_M1 : 3'd0;
                end else if (id_halt) begin
                    p         = 1'b1;
                    n         = 1'b1;
                    state_nxt = HALT;
                end
            end
            FLUSH: begin
                n = 1'b1;
                f = 1'b1;
                if (ex_branch_taken) cnt_nxt = FC_M1;
                else begin
                    cnt_nxt   = cnt == 3'd0 ? 3'd0 : cnt - 3'd1;
                    state_nxt = cnt <= 3'd1 ? RUN : FLUSH;
                end
            end
            default: begin
                p         = 1'b1;
                n         = 1'b1;
                h         = 1'b1;
                state_nxt = resume ? RUN : HALT;
            end
        endcase
    end

    // Mealy outputs are combinational from inputs, so they must be gated while reset is held.
    assign pause  = rst & p;
    assign nop    = rst & n;
    assign flush  = rst & f;
    assign halted = rst & h;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, pause & ~halted};
            flush_cycles <= flush_cycles + {31'd0, flush};
        end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed checks of hazard_ctrl against a remaining-cycle model.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int W  = 5;
    localparam int LL = 3;
    localparam int FC = 2;

    logic clk = 1'b0, rst = 1'b0;
    logic [W-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_rs1_used = 0, id_rs2_used = 0, id_halt = 0, ex_reg_write = 0, ex_is_load = 0;
    logic ex_branch_taken = 0, resume = 0;
    logic pause, nop, flush, halted;
    logic [31:0] insn;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_cycles;
    int unsigned m_sc = 0, m_fc = 0;
`endif

    int checks = 0, failures = 0;
    int m_stall = 0, m_flush = 0;
    bit m_halt = 0;
    bit o_pause, o_flush, o_halted;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(W), .LOAD_LAT(LL), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_halt(id_halt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken), .resume(resume),
        .pause(pause), .nop(nop), .flush(flush), .halted(halted)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit lu_f();
        return ex_is_load && ex_reg_write && ex_rd != 0 &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    endfunction

    task automatic clear_in();
        {id_rs1_used, id_rs2_used, ex_reg_write, ex_is_load, ex_branch_taken, resume} = '0;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        insn = NOP_INSN;
        id_halt = 1'b0;
    endtask

    // Called just after a negedge with inputs driven; checks, then advances one clock.
    task automatic step();
        bit ep = 0, en = 0, ef = 0, eh = 0;
        int ns = m_stall, nf = m_flush;
        bit nh = m_halt;
        #1;
        if (!rst) begin
            ns = 0; nf = 0; nh = 0;
        end else if (m_halt) begin
            ep = 1; en = 1; eh = 1;
            if (resume) nh = 0;
        end else if (m_flush > 0) begin
            en = 1; ef = 1;
            nf = ex_branch_taken ? FC - 1 : m_flush - 1;
        end else if (ex_branch_taken) begin
            ef = 1; en = 1; nf = FC - 1; ns = 0;
        end else if (m_stall > 0) begin
            ep = 1; en = 1; ns = m_stall - 1;
        end else if (lu_f()) begin
            ep = 1; en = 1; ns = LL - 1;
        end else if (id_halt) begin
            ep = 1; en = 1; nh = 1;
        end
        check("pause", 32'(pause), 32'(ep));
        check("nop", 32'(nop), 32'(en));
        check("flush", 32'(flush), 32'(ef));
        check("halted", 32'(halted), 32'(eh));
`ifdef HAZARD_PERF_EN
        check("stall_cycles", stall_cycles, m_sc);
        check("flush_cycles", flush_cycles, m_fc);
`endif
        o_pause = pause; o_flush = flush; o_halted = halted;
        @(posedge clk);
        m_stall = ns; m_flush = nf; m_halt = nh;
`ifdef HAZARD_PERF_EN
        if (!rst) begin m_sc = 0; m_fc = 0; end
        else begin m_sc += (ep && !eh) ? 1 : 0; m_fc += ef ? 1 : 0; end
`endif
        @(negedge clk);
    endtask

    task automatic async_rst();
        rst = 1'b0;
        #1;
        check("arst_pause", 32'(pause), 0);
        check("arst_nop", 32'(nop), 0);
        check("arst_flush", 32'(flush), 0);
        check("arst_halted", 32'(halted), 0);
        m_stall = 0; m_flush = 0; m_halt = 0;
`ifdef HAZARD_PERF_EN
        m_sc = 0; m_fc = 0;
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int cnt;
        clear_in();
        @(negedge clk);
        id_halt = 1'b1;
        ex_branch_taken = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        clear_in();
        repeat (2) step();

        ex_is_load = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
        step();
        cnt = int'(o_pause);
        clear_in();
        repeat (5) begin step(); cnt += int'(o_pause); end
        check("lu_len", cnt, LL);

        ex_is_load = 1; ex_reg_write = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
        step();
        check("lu_rd0", 32'(o_pause), 0);
        ex_rd = 5; id_rs1 = 5; id_rs1_used = 0;
        step();
        check("lu_unused", 32'(o_pause), 0);
        clear_in();

        ex_branch_taken = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1;
        step();
        check("br_prio_pause", 32'(o_pause), 0);
        cnt = int'(o_flush);
        clear_in();
        repeat (4) begin step(); cnt += int'(o_flush); end
        check("br_len", cnt, FC);

        insn = HALT_INSN; id_halt = (insn == HALT_INSN);
        step();
        clear_in();
        repeat (3) step();
        check("halt_hold", 32'(o_halted), 1);
        ex_branch_taken = 1;
        step();
        check("halt_br_ign", 32'(o_flush), 0);
        clear_in();
        resume = 1;
        step();
        resume = 0;
        step();
        check("resumed", 32'(o_halted), 0);
        resume = 1;
        step();
        resume = 0;
        id_halt = 1;
        step();
        clear_in();
        step();
        async_rst();
        repeat (2) step();

        for (int i = 0; i < 3000; i++) begin
            id_rs1 = W'($urandom_range(0, 3));
            id_rs2 = W'($urandom_range(0, 3));
            ex_rd = W'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom);
            id_rs2_used = 1'($urandom);
            ex_reg_write = 1'($urandom);
            ex_is_load = 1'($urandom);
            ex_branch_taken = $urandom_range(0, 7) == 0;
            insn = $urandom_range(0, 15) == 0 ? HALT_INSN : NOP_INSN;
            id_halt = insn == HALT_INSN;
            resume = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 299) == 0) async_rst();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the fetch/PC stage and the IF/ID and ID/EX registers.
- Generates `pause` (hold PC and fetched instruction), `nop` (inject a bubble into ID/EX) and `flush` (kill wrong-path instructions after a taken branch).
- Handles three events: load-use hazards with a configurable stall length, branch redirect with configurable bubble cycles, and a halt/resume mechanism for a decoded halt instruction.

Parameters:
- REG_ADDR_W, 5, register-index width.
- LOAD_LAT, 1, stall cycles inserted per load-use hazard (legal range 1..7).
- FLUSH_CYCLES, 1, bubble cycles after a taken branch, including the redirect cycle (legal range 1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_ADDR_W  source register 1 of the instruction in ID.
- id_rs2  in  REG_ADDR_W  source register 2 of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- id_halt  in  1  ID instruction is the halt encoding (32'hFFFFFFFF).
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- ex_reg_write  in  1  EX instruction writes rd.
- ex_is_load  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump; PC takes the target this cycle.
- resume  in  1  single-cycle pulse that leaves HALT.
- pause  out  1  hold PC and IF/ID.
- nop  out  1  force a bubble (32'h00000013) into ID/EX.
- flush  out  1  kill IF/ID contents (wrong path).
- halted  out  1  core is halted.

Behaviour:
- States: RUN, STALL, FLUSH, HALT. The state and a 3-bit counter `cnt` are registered. Outputs are Mealy (combinational from state and inputs), so the first stall or flush cycle takes effect in the same cycle the event is seen.
- While rst is low:
  - state = RUN, cnt = 0.
  - pause, nop, flush and halted are all forced to 0.
  - Reset asserted mid-operation in any state returns to RUN with no residual outputs.
- Load-use hazard is defined as: `lu = ex_is_load & ex_reg_write & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd))`.
- Priority each cycle: ex_branch_taken > lu > id_halt.
- RUN:
  - Branch: flush = 1, pause = 0, nop = 1. If FLUSH_CYCLES > 1, go to FLUSH with cnt = FLUSH_CYCLES-1.
  - Else if lu: pause = 1, nop = 1. If LOAD_LAT > 1, go to STALL with cnt = LOAD_LAT-1; otherwise stay in RUN.
  - Else if id_halt: pause = 1, nop = 1, go to HALT.
  - Else all outputs are 0.
- STALL:
  - pause = 1, nop = 1.
  - cnt decrements each cycle; return to RUN on the cycle cnt == 1.
  - A branch in STALL aborts the stall and takes the RUN branch action, including the FLUSH entry.
- FLUSH:
  - nop = 1, flush = 1, pause = 0.
  - cnt decrements; return to RUN when cnt == 1.
  - A new branch in FLUSH reloads cnt = FLUSH_CYCLES-1.
  - lu and id_halt are ignored while in FLUSH, since ID holds wrong-path instructions.
- HALT:
  - pause = 1, nop = 1, halted = 1.
  - ex_branch_taken and lu are ignored.
  - resume = 1 moves to RUN next cycle; halted drops the cycle after.
  - resume outside HALT has no effect.
- flush is never asserted together with pause = 1.
- cnt never underflows.

Optional Feature:
- HAZARD_PERF_EN.
- When defined, adds outputs `stall_cycles[31:0]` and `flush_cycles[31:0]`, both reset to 0:
  - stall_cycles increments on every cycle with pause = 1 and halted = 0.
  - flush_cycles increments on every cycle with flush = 1.
  - Both counters wrap modulo 2^32.
- When undefined, these ports and their logic are absent and the remaining behaviour is identical.

Decomposition:
- The shared package holds the state enum (RUN = 0, STALL = 1, FLUSH = 2, HALT = 3), the NOP encoding 32'h00000013 and the halt encoding 32'hFFFFFFFF.
- One sub-module, `hazard_detect`: purely combinational computation of lu from the ID and EX fields. The FSM stays in hazard_ctrl.

Test Plan:
- Reset and idle: rst low for 3 cycles with id_halt = 1 → all outputs 0. Release rst with no hazards → outputs stay 0 and state is RUN.
- Load-use, LOAD_LAT = 2: ex_is_load = 1, ex_reg_write = 1, ex_rd = 5, id_rs1 = 5, id_rs1_used = 1 → pause = nop = 1 for exactly 2 cycles, then 0.
- Load-use filtered: ex_rd = 0 with a matching rs1, or ex_rd = 5 with id_rs1_used = 0 → pause = 0.
- Branch priority, FLUSH_CYCLES = 2: ex_branch_taken = 1 together with lu = 1 → cycle 0: flush = 1, nop = 1, pause = 0. Cycle 1: flush = 1, nop = 1. Cycle 2: RUN.
- Halt/resume: id_halt = 1 → pause = nop = halted = 1 indefinitely; a branch pulse is ignored; a resume pulse → RUN next cycle and outputs 0. An async rst pulse while in HALT → immediate RUN.
- HAZARD_PERF_EN: run the load-use test (2 cycles) plus the branch test (2 cycles) → stall_cycles = 2, flush_cycles = 2. Preload stall_cycles = 32'hFFFFFFFF, then 1 stall cycle → wraps to 0.
